// File: rtl/pkt_alu_defs.sv
// Shared definitions for the packet ALU: opcodes, FSM states, status marker
// and header field positions.
package pkt_alu_defs;

    localparam logic [7:0] OP_SUM    = 8'h01;
    localparam logic [7:0] OP_XOR    = 8'h02;
    localparam logic [7:0] OP_MAX    = 8'h03;
    localparam logic [7:0] STAT_MARK = 8'hA5;

    localparam int HDR_OP_HI = 31;
    localparam int HDR_OP_LO = 24;
    localparam int HDR_N_HI  = 15;
    localparam int HDR_N_LO  = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_WAIT  = 3'd1,
        OPND_RD   = 3'd2,
        OPND_WAIT = 3'd3,
`ifdef PKT_ALU_STATUS_WORD_EN
        OUT_RES   = 3'd4,
        OUT_STAT  = 3'd5
`else
        OUT_RES   = 3'd4
`endif
    } state_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_SUM) || (op == OP_XOR) || (op == OP_MAX);
    endfunction

endpackage

// File: rtl/fifo_packet_alu_if.sv
// FIFO-side bus of the packet ALU: pop port of the input FIFO and push port
// of the return FIFO. master = ALU, slave = FIFO pair.
interface fifo_packet_alu_if;

    logic        data_empty;
    logic        data_rd;
    logic [31:0] data_din;
    logic        data_full;
    logic        data_wr;
    logic [31:0] data_dout;

    modport master (
        input  data_empty, data_din, data_full,
        output data_rd, data_wr, data_dout
    );

    modport slave (
        output data_empty, data_din, data_full,
        input  data_rd, data_wr, data_dout
    );

endinterface

// File: rtl/pkt_alu_op.sv
// Combinational reduction step: folds one operand into the accumulator
// according to the opcode and flags opcodes it does not know.
module pkt_alu_op
    import pkt_alu_defs::*;
(
    input  logic [7:0]  opcode,
    input  logic [31:0] acc,
    input  logic [31:0] din,
    output logic [31:0] next_acc,
    output logic        carry,
    output logic        bad_op
);

    logic [32:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, din};
        next_acc = acc;
        carry    = 1'b0;
        bad_op   = 1'b0;
        case (opcode)
            OP_SUM: begin
                next_acc = sum[31:0];
                carry    = sum[32];
            end
            OP_XOR:  next_acc = acc ^ din;
            OP_MAX:  next_acc = (din > acc) ? din : acc;
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/fifo_packet_alu.sv
// Packet ALU between the host FIFOs: pops a header and N operands, pushes the
// reduced result. Define PKT_ALU_STATUS_WORD_EN to append a status word.
module fifo_packet_alu
    import pkt_alu_defs::*;
#(
    parameter logic [15:0] MAX_COUNT = 16'd256,
    parameter logic [15:0] ERR_TAG   = 16'hDEAD
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n_sync,
    fifo_packet_alu_if.master bus,
    output logic              busy
);

    state_t      state;
    state_t      state_next;
    logic [31:0] acc;
    logic [15:0] remaining;
    logic [7:0]  opcode;
    logic [7:0]  err_code;
    logic        err;
    logic [7:0]  hdr_op;
    logic [15:0] hdr_n;
    logic [31:0] op_next_acc;
    logic        op_bad;
    logic        rd;
    logic        wr;
    logic [31:0] dout;

    assign hdr_op = bus.data_din[HDR_OP_HI:HDR_OP_LO];
    assign hdr_n  = bus.data_din[HDR_N_HI:HDR_N_LO];

`ifdef PKT_ALU_STATUS_WORD_EN
    logic ovf;
    logic op_carry;

    pkt_alu_op u_op (
        .opcode   (opcode),
        .acc      (acc),
        .din      (bus.data_din),
        .next_acc (op_next_acc),
        .carry    (op_carry),
        .bad_op   (op_bad)
    );
`else
    pkt_alu_op u_op (
        .opcode   (opcode),
        .acc      (acc),
        .din      (bus.data_din),
        .next_acc (op_next_acc),
        .carry    (),
        .bad_op   (op_bad)
    );
`endif

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) state <= IDLE;
        else                  state <= state_next;
    end

    // Read strobe is gated by reset so nothing pops while reset is held.
    always_comb begin
        state_next = state;
        rd         = 1'b0;
        wr         = 1'b0;
        dout       = 32'h0;
        case (state)
            IDLE: begin
                rd = !bus.data_empty && rst_main_n_sync;
                if (rd) state_next = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (hdr_n == 16'd0 || hdr_n > MAX_COUNT) state_next = OUT_RES;
                else                                     state_next = OPND_RD;
            end
            OPND_RD: begin
                rd = !bus.data_empty && rst_main_n_sync;
                if (rd) state_next = OPND_WAIT;
            end
            OPND_WAIT: begin
                state_next = (remaining == 16'd1) ? OUT_RES : OPND_RD;
            end
            OUT_RES: begin
                dout = err ? {ERR_TAG, 8'h00, err_code} : acc;
                wr   = !bus.data_full;
`ifdef PKT_ALU_STATUS_WORD_EN
                if (wr) state_next = OUT_STAT;
`else
                if (wr) state_next = IDLE;
`endif
            end
`ifdef PKT_ALU_STATUS_WORD_EN
            OUT_STAT: begin
                dout = {STAT_MARK, opcode, 6'b0, err, ovf, 8'h00};
                wr   = !bus.data_full;
                if (wr) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign bus.data_rd   = rd;
    assign bus.data_wr   = wr;
    assign bus.data_dout = dout;
    assign busy          = (state != IDLE);

    // An oversized count reports 8'hFF in place of the opcode in the error word.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            acc       <= 32'h0;
            remaining <= 16'h0;
            opcode    <= 8'h00;
            err_code  <= 8'h00;
            err       <= 1'b0;
`ifdef PKT_ALU_STATUS_WORD_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                HDR_WAIT: begin
                    opcode    <= hdr_op;
                    remaining <= hdr_n;
                    acc       <= 32'h0;
`ifdef PKT_ALU_STATUS_WORD_EN
                    ovf       <= 1'b0;
`endif
                    if (hdr_n > MAX_COUNT) begin
                        err      <= 1'b1;
                        err_code <= 8'hFF;
                    end else begin
                        err      <= !is_known_op(hdr_op);
                        err_code <= hdr_op;
                    end
                end
                OPND_WAIT: begin
                    remaining <= remaining - 16'd1;
                    if (op_bad) begin
                        err <= 1'b1;
                    end else begin
                        acc <= op_next_acc;
`ifdef PKT_ALU_STATUS_WORD_EN
                        ovf <= ovf | op_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packet_alu.sv
// Directed bench for fifo_packet_alu: a queue-backed input FIFO, a logging
// output FIFO, a vector table and hand sequences for stalls and reset.
module tb_fifo_packet_alu;

`ifdef PKT_ALU_STATUS_WORD_EN
    localparam int WORDS = 2;
`else
    localparam int WORDS = 1;
`endif

    typedef struct {
        string       name;
        logic [31:0] hdr;
        int          n;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp_res;
        logic [31:0] exp_stat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    fifo_packet_alu_if bus ();

    fifo_packet_alu dut (
        .clk_main_a0     (clk),
        .rst_main_n_sync (rst_n),
        .bus             (bus),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    int          rd_log[$];
    int          wr_log[$];
    int          cycle;
    int          popped;
    int          applied;
    int          miscompares;
    vec_t        vecs[$];

    // Output-side monitor: logs every strobe, flags strobes against empty/full.
    initial begin
        cycle = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (bus.data_rd === 1'b1) begin
                rd_log.push_back(cycle);
                if (bus.data_empty) begin
                    $display("[TB] FAIL rd_while_empty: got data_rd=1, expected 0 at cycle %0d", cycle);
                    miscompares++;
                end
            end
            if (bus.data_wr === 1'b1) begin
                out_q.push_back(bus.data_dout);
                wr_log.push_back(cycle);
                if (bus.data_full) begin
                    $display("[TB] FAIL wr_while_full: got data_wr=1, expected 0 at cycle %0d", cycle);
                    miscompares++;
                end
            end
        end
    end

    // Input FIFO model: dout follows a read strobe by one cycle.
    initial begin
        popped         = 0;
        bus.data_din   = 32'h0;
        bus.data_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_log.size() > popped) begin
                popped++;
                if (in_q.size() > 0) bus.data_din = in_q.pop_front();
            end
            bus.data_empty = (in_q.size() == 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string name, logic [31:0] hdr, int n,
                                logic [31:0] op0, logic [31:0] op1, logic [31:0] op2,
                                logic [31:0] exp_res, logic [31:0] exp_stat);
        vec_t v;
        v.name = name; v.hdr = hdr; v.n = n;
        v.op0 = op0; v.op1 = op1; v.op2 = op2;
        v.exp_res = exp_res; v.exp_stat = exp_stat;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_words(string name, int target, int budget);
        int k = 0;
        while (out_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (out_q.size() < target) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: got %0d words, expected %0d", name, out_q.size(), target);
        end
    endtask

    task automatic wait_reads(string name, int target, int budget);
        int k = 0;
        while (rd_log.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (rd_log.size() < target) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s_rd_timeout: got %0d reads, expected %0d", name, rd_log.size(), target);
        end
    endtask

    task automatic apply_stimulus(vec_t v);
        int rd0 = rd_log.size();
        int w0  = out_q.size();
        in_q.push_back(v.hdr);
        if (v.n > 0) in_q.push_back(v.op0);
        if (v.n > 1) in_q.push_back(v.op1);
        if (v.n > 2) in_q.push_back(v.op2);
        wait_words(v.name, w0 + WORDS, 100 + 4 * v.n);
        repeat (4) tick();
        check_output({v.name, "_count"}, out_q.size() - w0, WORDS);
        check_output({v.name, "_drain"}, in_q.size(), 0);
        if (out_q.size() > w0 && rd_log.size() > rd0) begin
            check_output({v.name, "_result"}, out_q[w0], v.exp_res);
            check_output({v.name, "_latency"}, wr_log[w0] - rd_log[rd0], 2 + 2 * v.n);
        end
`ifdef PKT_ALU_STATUS_WORD_EN
        if (out_q.size() > w0 + 1)
            check_output({v.name, "_status"}, out_q[w0 + 1], v.exp_stat);
`endif
    endtask

    initial begin
        int rd0;
        int w0;
        logic ok;

        rst_n         = 1'b0;
        bus.data_full = 1'b0;
        applied       = 0;
        miscompares   = 0;

        vecs.push_back(mk("sum3",     32'h0100_0003, 3, 32'd1, 32'd2, 32'd3, 32'h0000_0006, 32'hA501_0000));
        vecs.push_back(mk("sum_wrap", 32'h0100_0002, 2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0000_0001, 32'hA501_0100));
        vecs.push_back(mk("max3",     32'h0300_0003, 3, 32'd5, 32'h8000_0000, 32'd7, 32'h8000_0000, 32'hA503_0000));
        vecs.push_back(mk("xor2",     32'h0200_0002, 2, 32'hF0F0_F0F0, 32'h0FF0_0000, 32'd0, 32'hFF00_F0F0, 32'hA502_0000));
        vecs.push_back(mk("bad_op",   32'h7700_0002, 2, 32'd11, 32'd22, 32'd0, 32'hDEAD_0077, 32'hA577_0200));
        vecs.push_back(mk("sum_after",32'h0100_0002, 2, 32'd10, 32'd20, 32'd0, 32'h0000_001E, 32'hA501_0000));
        vecs.push_back(mk("sum_n0",   32'h0100_0000, 0, 32'd0, 32'd0, 32'd0, 32'h0000_0000, 32'hA501_0000));
        vecs.push_back(mk("n_over",   32'h0100_0101, 0, 32'd0, 32'd0, 32'd0, 32'hDEAD_00FF, 32'hA501_0200));
        vecs.push_back(mk("max_uns",  32'h0300_0002, 2, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFE, 32'hA503_0000));
        vecs.push_back(mk("xor1",     32'h0200_0001, 1, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678, 32'hA502_0000));
        vecs.push_back(mk("bad_n0",   32'h0500_0000, 0, 32'd0, 32'd0, 32'd0, 32'hDEAD_0005, 32'hA505_0200));
        vecs.push_back(mk("rsvd",     32'h01FF_0002, 2, 32'd7, 32'd8, 32'd0, 32'h0000_000F, 32'hA501_0000));

        repeat (3) tick();
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_rd",   bus.data_rd, 1'b0);
        check_output("reset_wr",   bus.data_wr, 1'b0);
        check_output("reset_dout", bus.data_dout, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Empty stall mid-packet: only the first operand is available.
        rd0 = rd_log.size();
        w0  = out_q.size();
        in_q.push_back(32'h0100_0002);
        in_q.push_back(32'd5);
        wait_reads("stall", rd0 + 2, 50);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.data_rd !== 1'b0 || bus.data_wr !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check_output("stall_idle_bus", ok, 1'b1);
        check_output("stall_no_read", rd_log.size() - rd0, 2);
        check_output("stall_no_write", out_q.size() - w0, 0);
        in_q.push_back(32'd6);
        wait_words("stall", w0 + WORDS, 50);
        if (out_q.size() > w0) check_output("stall_result", out_q[w0], 32'h0000_000B);
        repeat (3) tick();

        // Output backpressure: full held for 4 cycles of OUT_RES.
        rd0 = rd_log.size();
        w0  = out_q.size();
        bus.data_full = 1'b1;
        in_q.push_back(32'h0200_0001);
        in_q.push_back(32'hA5A5_0000);
        wait_reads("full", rd0 + 2, 50);
        tick();
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.data_wr !== 1'b0 || bus.data_dout !== 32'hA5A5_0000 || busy !== 1'b1) ok = 1'b0;
        end
        check_output("full_hold", ok, 1'b1);
        @(posedge clk);
        #1 bus.data_full = 1'b0;
        tick();
        check_output("full_release_wr", out_q.size() - w0, 1);
        if (out_q.size() > w0) check_output("full_result", out_q[w0], 32'hA5A5_0000);
        wait_words("full", w0 + WORDS, 20);
        repeat (3) tick();

        // Largest legal count: 256 ones sum to 0x100.
        rd0 = rd_log.size();
        w0  = out_q.size();
        in_q.push_back(32'h0100_0100);
        for (int i = 0; i < 256; i++) in_q.push_back(32'd1);
        wait_words("max_count", w0 + WORDS, 700);
        if (out_q.size() > w0) begin
            check_output("max_count_result", out_q[w0], 32'h0000_0100);
            check_output("max_count_latency", wr_log[w0] - rd_log[rd0], 2 + 2 * 256);
        end
        repeat (3) tick();

        // Reset while in OPND_WAIT of the first operand.
        rd0 = rd_log.size();
        w0  = out_q.size();
        in_q.push_back(32'h0100_0003);
        in_q.push_back(32'd1);
        in_q.push_back(32'd2);
        in_q.push_back(32'd3);
        wait_reads("rst", rd0 + 2, 50);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_rd",   bus.data_rd, 1'b0);
        check_output("rst_wr",   bus.data_wr, 1'b0);
        check_output("rst_dout", bus.data_dout, 32'h0);
        check_output("rst_left_in_fifo", in_q.size(), 2);
        in_q.delete();
        repeat (3) tick();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        check_output("rst_no_write", out_q.size() - w0, 0);

        apply_stimulus(mk("post_rst", 32'h0100_0002, 2, 32'd100, 32'd23, 32'd0, 32'h0000_007B, 32'hA501_0000));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
